// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control sequencer: states, opcodes,
// ALUOp, mux selects and ALUControl codes.
package multicycle_control_fsm_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10,
      TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

   // Immediate format is a pure function of the opcode, valid in every state.
   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_STORE:  return IMM_S;
         OP_BRANCH: return IMM_B;
         OP_JAL:    return IMM_J;
         default:   return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU_Decoder: maps ALUOp plus funct fields onto the 3-bit ALUControl code.
module ALU_Decoder
   import multicycle_control_fsm_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       op5_i,
   input  logic [6:0] funct7_i,
   output logic [2:0] alu_control_o
);

   logic is_sub;

   // Only R-type (op bit 5 set) with the alternate funct7 encodes a subtract.
   assign is_sub = op5_i && (funct7_i == FUNCT7_ALT);

   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_ADD: alu_control_o = ALU_ADD;
         ALUOP_SUB: alu_control_o = ALU_SUB;
         default: begin
            case (funct3_i)
               3'b000:  alu_control_o = is_sub ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control_o = ALU_SLT;
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer: walks each instruction through its phases,
// stalls on mem_ready, and traps on illegal opcodes or memory timeout.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] Op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       instr_retired,
   output logic       trap
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
   localparam bit               TIMEOUT_EN  = (MEM_TIMEOUT != 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [1:0]       alu_op;
   logic             mem_state;
   logic             timeout_hit;
   logic             pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, retire_raw;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FETCH;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign mem_state   = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
   assign timeout_hit = TIMEOUT_EN && mem_state && !mem_ready && (wait_cnt_q == TIMEOUT_CNT);

   always_comb begin
      state_d       = state_q;
      AdrSrc        = 1'b0;
      ResultSrc     = RES_ALUOUT;
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_RD2;
      ImmSrc        = imm_src_of(Op);
      alu_op        = ALUOP_ADD;
      pc_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      retire_raw    = 1'b0;

      case (state_q)
         FETCH: begin
            ALUSrcB      = SRCB_FOUR;
            ResultSrc    = RES_ALURESULT;
            ir_write_raw = mem_ready;
            pc_write_raw = mem_ready;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            // OldPC + ImmExt lands in ALUOut as the branch/jump target.
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (Op)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_RTYPE:          state_d = EXECR;
               OP_ITYPE:          state_d = EXECI;
               OP_BRANCH:         state_d = BEQ;
               OP_JAL:            state_d = JAL;
               default:           state_d = TRAP;
            endcase
         end
         MEMADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            if (Op == OP_LOAD)       state_d = MEMREAD;
            else if (Op == OP_STORE) state_d = MEMWRITE;
            else                     state_d = TRAP;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            ResultSrc     = RES_DATA;
            reg_write_raw = 1'b1;
            retire_raw    = 1'b1;
            state_d       = FETCH;
         end
         MEMWRITE: begin
            AdrSrc        = 1'b1;
            mem_write_raw = 1'b1;
            if (mem_ready) begin
               retire_raw = 1'b1;
               state_d    = FETCH;
            end
         end
         EXECR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            alu_op  = ALUOP_FUNCT;
            state_d = ALUWB;
         end
         EXECI: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
            state_d = ALUWB;
         end
         ALUWB: begin
            reg_write_raw = 1'b1;
            retire_raw    = 1'b1;
            state_d       = FETCH;
         end
         BEQ: begin
            ALUSrcA      = SRCA_RD1;
            ALUSrcB      = SRCB_RD2;
            alu_op       = ALUOP_SUB;
            pc_write_raw = Zero;
            retire_raw   = 1'b1;
            state_d      = FETCH;
         end
         JAL: begin
            // PC takes the target held in ALUOut while OldPC + 4 is computed for rd.
            ALUSrcA      = SRCA_OLDPC;
            ALUSrcB      = SRCB_FOUR;
            pc_write_raw = 1'b1;
            state_d      = ALUWB;
         end
         TRAP: begin
            state_d = TRAP;
         end
         default: state_d = TRAP;
      endcase

      if (timeout_hit) state_d = TRAP;
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (mem_ready || (state_d != state_q)) begin
         wait_cnt_d = '0;
      end else if (mem_state && (wait_cnt_q != '1)) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
   end

   // Enables are masked while rst is held so an abort never leaks a write.
   assign PCWrite       = rst & pc_write_raw;
   assign MemWrite      = rst & mem_write_raw;
   assign IRWrite       = rst & ir_write_raw;
   assign RegWrite      = rst & reg_write_raw;
   assign instr_retired = rst & retire_raw;
   assign trap          = (state_q == TRAP);

   ALU_Decoder u_alu_decoder (
      .alu_op_i      (alu_op),
      .funct3_i      (funct3),
      .op5_i         (Op[5]),
      .funct7_i      (funct7),
      .alu_control_o (ALUControl)
   );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench for multicycle_control_fsm: the driver queues per-cycle
// expected outputs and instruction latencies; a negedge monitor compares them.
module tb_multicycle_control_fsm;

   localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011;
   localparam logic [6:0] T_I = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [6:0] Op = '0;
   logic [2:0] funct3 = '0;
   logic [6:0] funct7 = '0;
   logic Zero = 1'b0, mem_ready = 1'b0;

   logic a_pcw, a_adr, a_mw, a_irw, a_rw, a_ret, a_trap;
   logic [1:0] a_rs, a_sa, a_sb, a_imm;
   logic [2:0] a_alu;
   logic b_pcw, b_adr, b_mw, b_irw, b_rw, b_ret, b_trap;
   logic [1:0] b_rs, b_sa, b_sb, b_imm;
   logic [2:0] b_alu;
   logic [17:0] act_a, act_b;

   assign act_a = {a_pcw, a_adr, a_mw, a_irw, a_rw, a_rs, a_sa, a_sb, a_imm, a_alu, a_ret, a_trap};
   assign act_b = {b_pcw, b_adr, b_mw, b_irw, b_rw, b_rs, b_sa, b_sb, b_imm, b_alu, b_ret, b_trap};

   multicycle_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
      .mem_ready(mem_ready), .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_mw),
      .IRWrite(a_irw), .RegWrite(a_rw), .ResultSrc(a_rs), .ALUSrcA(a_sa), .ALUSrcB(a_sb),
      .ImmSrc(a_imm), .ALUControl(a_alu), .instr_retired(a_ret), .trap(a_trap));

   multicycle_control_fsm #(.MEM_TIMEOUT(0), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
      .mem_ready(mem_ready), .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_mw),
      .IRWrite(b_irw), .RegWrite(b_rw), .ResultSrc(b_rs), .ALUSrcA(b_sa), .ALUSrcB(b_sb),
      .ImmSrc(b_imm), .ALUControl(b_alu), .instr_retired(b_ret), .trap(b_trap));

   always #5 clk = ~clk;

   typedef enum int {P_RST, P_FETCH, P_DEC, P_ADR, P_RD, P_RDWB, P_WR,
                     P_EXR, P_EXI, P_WB, P_BR, P_JAL, P_TRAP} ph_e;
   typedef struct {
      logic [17:0] e;
      logic [17:0] e0;
      bit          first;
      ph_e         ph;
      ph_e         ph0;
   } exp_t;

   exp_t expq[$];
   int   lat_q[$];
   int   checks = 0, failures = 0;
   int   lat_cnt = 0;
   logic [6:0] cur_op = '0, cur_f7 = '0;
   logic [2:0] cur_f3 = '0;
   logic       br_zero = 1'b0;

   function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
      case (f3)
         3'b000:  return sub ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Expected output vector for one cycle of a given instruction phase.
   function automatic logic [17:0] expv(input ph_e ph, input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic mr, input logic z);
      logic pcw, adr, mw, irw, rw, ret, trp;
      logic [1:0] rs, sa, sb, imm;
      logic [2:0] alu;
      {pcw, adr, mw, irw, rw, ret, trp} = '0;
      {rs, sa, sb} = '0;
      alu = 3'b000;
      case (op)
         T_STORE: imm = 2'b01;
         T_BR:    imm = 2'b10;
         T_JAL:   imm = 2'b11;
         default: imm = 2'b00;
      endcase
      case (ph)
         P_RST:   begin sb = 2'b10; rs = 2'b10; end
         P_FETCH: begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
         P_DEC:   begin sa = 2'b01; sb = 2'b01; end
         P_ADR:   begin sa = 2'b10; sb = 2'b01; end
         P_RD:    adr = 1'b1;
         P_RDWB:  begin rs = 2'b01; rw = 1'b1; ret = 1'b1; end
         P_WR:    begin adr = 1'b1; mw = 1'b1; ret = mr; end
         P_EXR:   begin sa = 2'b10; alu = alu_of(f3, op[5] && (f7 == 7'b0100000)); end
         P_EXI:   begin sa = 2'b10; sb = 2'b01; alu = alu_of(f3, op[5] && (f7 == 7'b0100000)); end
         P_WB:    begin rw = 1'b1; ret = 1'b1; end
         P_BR:    begin sa = 2'b10; alu = 3'b001; pcw = z; ret = 1'b1; end
         P_JAL:   begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
         default: trp = 1'b1;
      endcase
      return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ret, trp};
   endfunction

   task automatic chk_vec(input string name, input logic [17:0] act, input logic [17:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%b want=%b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle: drive inputs just after the edge and queue what both DUTs should show.
   task automatic cyc(input ph_e ph, input ph_e ph0, input logic mr, input bit first);
      exp_t x;
      @(posedge clk);
      #1;
      if (ph == P_RST) rst = 1'b0;
      Op = cur_op;
      funct3 = cur_f3;
      funct7 = cur_f7;
      mem_ready = mr;
      Zero = (ph == P_BR) ? br_zero : 1'($urandom_range(0, 1));
      x.e = expv(ph, cur_op, cur_f3, cur_f7, mr, Zero);
      x.e0 = expv(ph0, cur_op, cur_f3, cur_f7, mr, Zero);
      x.first = first;
      x.ph = ph;
      x.ph0 = ph0;
      expq.push_back(x);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cyc(P_RST, P_RST, 1'($urandom_range(0, 1)), 1'b0);
      @(negedge clk);
      #1;
      mem_ready = 1'b0;
      rst = 1'b1;
      $display("reset released after %0d cycles", n);
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input int fs, input int ms, input bit z, input bit abort_wb);
      int lat;
      bit legal;
      cur_op = op; cur_f3 = f3; cur_f7 = f7; br_zero = z;
      legal = 1'b1;
      case (op)
         T_LOAD:          lat = fs + 4 + ms + 1;
         T_STORE:         lat = fs + 3 + ms + 1;
         T_R, T_I, T_JAL: lat = fs + 4;
         T_BR:            lat = fs + 3;
         default: begin lat = 0; legal = 1'b0; end
      endcase
      if (legal) lat_q.push_back(lat);
      $display("instr op=%b f3=%b f7=%b fstall=%0d mstall=%0d zero=%0b lat=%0d", op, f3, f7, fs, ms, z, lat);
      for (int k = 0; k <= fs; k++) cyc(P_FETCH, P_FETCH, k == fs, k == 0);
      cyc(P_DEC, P_DEC, 1'($urandom_range(0, 1)), 1'b0);
      case (op)
         T_LOAD: begin
            cyc(P_ADR, P_ADR, 1'($urandom_range(0, 1)), 1'b0);
            for (int k = 0; k <= ms; k++) cyc(P_RD, P_RD, k == ms, 1'b0);
            cyc(P_RDWB, P_RDWB, 1'($urandom_range(0, 1)), 1'b0);
            if (abort_wb) begin
               @(negedge clk);
               #1;
               rst = 1'b0;
               #1;
               chk_vec("abort_writes", {13'b0, a_rw, a_ret, b_rw, b_ret, a_pcw}, 18'b0);
               do_reset(2);
            end
         end
         T_STORE: begin
            cyc(P_ADR, P_ADR, 1'($urandom_range(0, 1)), 1'b0);
            for (int k = 0; k <= ms; k++) cyc(P_WR, P_WR, k == ms, 1'b0);
         end
         T_R:   begin cyc(P_EXR, P_EXR, 1'($urandom_range(0, 1)), 1'b0); cyc(P_WB, P_WB, 1'($urandom_range(0, 1)), 1'b0); end
         T_I:   begin cyc(P_EXI, P_EXI, 1'($urandom_range(0, 1)), 1'b0); cyc(P_WB, P_WB, 1'($urandom_range(0, 1)), 1'b0); end
         T_BR:  cyc(P_BR, P_BR, 1'($urandom_range(0, 1)), 1'b0);
         T_JAL: begin cyc(P_JAL, P_JAL, 1'($urandom_range(0, 1)), 1'b0); cyc(P_WB, P_WB, 1'($urandom_range(0, 1)), 1'b0); end
         default: for (int k = 0; k < 22; k++) cyc(P_TRAP, P_TRAP, 1'($urandom_range(0, 1)), 1'b0);
      endcase
   endtask

   task automatic run_random(input int n);
      logic [6:0] ops [6];
      logic [2:0] f3s [4];
      ops = '{T_LOAD, T_STORE, T_R, T_I, T_BR, T_JAL};
      f3s = '{3'b000, 3'b010, 3'b110, 3'b111};
      for (int i = 0; i < n; i++)
         run_instr(ops[$urandom_range(0, 5)], f3s[$urandom_range(0, 3)],
                   ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'b0);
   endtask

   // Monitor: one comparison per DUT per queued cycle, plus latency on each retire.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            x = expq.pop_front();
            lat_cnt = x.first ? 1 : lat_cnt + 1;
            chk_vec($sformatf("%s/to15", x.ph.name()), act_a, x.e);
            chk_vec($sformatf("%s/to0", x.ph0.name()), act_b, x.e0);
            if (a_ret === 1'b1) begin
               if (lat_q.size() == 0) chk_int("unexpected_retire", 1, 0);
               else chk_int("latency", lat_cnt, lat_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      #3 rst = 1'b0;
      do_reset(2);
      run_instr(T_R, 3'b000, 7'b0000000, 0, 0, 1'b0, 1'b0);
      run_instr(T_LOAD, 3'b010, 7'b0000000, 0, 3, 1'b0, 1'b0);
      run_instr(T_BR, 3'b000, 7'b0000000, 0, 0, 1'b1, 1'b0);
      run_instr(T_BR, 3'b000, 7'b0000000, 0, 0, 1'b0, 1'b0);
      run_instr(T_JAL, 3'b000, 7'b0000000, 0, 0, 1'b0, 1'b0);
      run_instr(T_STORE, 3'b010, 7'b0000000, 0, 0, 1'b0, 1'b0);
      run_instr(T_R, 3'b000, 7'b0100000, 2, 0, 1'b0, 1'b0);
      run_random(60);

      run_instr(7'b0000000, 3'b000, 7'b0000000, 0, 0, 1'b0, 1'b0);
      do_reset(2);

      // Store stuck on memory: the timeout instance traps, the other keeps waiting.
      cur_op = T_STORE; cur_f3 = 3'b010; cur_f7 = '0;
      $display("instr sw timeout sequence");
      cyc(P_FETCH, P_FETCH, 1'b1, 1'b1);
      cyc(P_DEC, P_DEC, 1'b0, 1'b0);
      cyc(P_ADR, P_ADR, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) cyc(P_WR, P_WR, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) cyc(P_TRAP, P_WR, 1'b0, 1'b0);
      cyc(P_TRAP, P_WR, 1'b1, 1'b0);
      do_reset(2);

      run_instr(T_LOAD, 3'b010, 7'b0000000, 1, 1, 1'b0, 1'b1);
      run_random(12);

      repeat (3) @(negedge clk);
      #1;
      chk_int("expq_drained", expq.size(), 0);
      chk_int("latq_drained", lat_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle sequencer for the RV32I core datapath with a shared instruction/data memory.
- Walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the per-cycle datapath enables and mux selects.
- Stalls on a memory-ready handshake and traps on illegal opcodes or memory timeout.
- Derives ALUControl by instantiating the existing ALU_Decoder.

Parameters:
- MEM_TIMEOUT, 15, maximum consecutive wait cycles on mem_ready before trapping; 0 disables the timeout.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous active-low reset.
- Op  input  7  opcode from the instruction register.
- funct3  input  3  instruction funct3.
- funct7  input  7  instruction funct7.
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register and OldPC enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  output  3  from ALU_Decoder.
- instr_retired  output  1  one-cycle pulse on the final cycle of each instruction.
- trap  output  1  sticky error flag.

Behaviour:
- Reset (rst low, asynchronous): state = FETCH, wait counter = 0, trap = 0.
  - While rst is low, PCWrite, IRWrite, RegWrite, MemWrite and instr_retired are forced to 0.
  - Mux selects take their FETCH values.
  - The first FETCH cycle follows the first clk edge after rst deasserts.
- Outputs are Moore decodes of state, qualified only by mem_ready, Zero and Op.
- Any output not listed for a state is 0.
- ImmSrc is decoded from Op in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- FETCH: AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10.
  - IRWrite = PCWrite = mem_ready.
  - mem_ready → DECODE; otherwise stay.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (branch target into ALUOut). Next state by Op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other → TRAP
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: AdrSrc = 1, ResultSrc = 00. mem_ready → MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, retire → FETCH.
- MEMWRITE: AdrSrc = 1, ResultSrc = 00, MemWrite = 1 held until mem_ready. mem_ready → retire → FETCH.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10 → ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10 → ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, retire → FETCH.
- BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, PCWrite = Zero, retire → FETCH.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCWrite = 1 → ALUWB (rd = PC+4).
- TRAP: all enables 0, trap = 1. Absorbing; only rst exits.
- Wait counter:
  - Increments in FETCH/MEMREAD/MEMWRITE while mem_ready = 0.
  - Clears on mem_ready = 1 and on any state change.
  - If MEM_TIMEOUT ≠ 0 and counter == MEM_TIMEOUT with mem_ready = 0 → TRAP next cycle. No write is issued on that cycle except the held MemWrite.
  - Saturates; no wrap.
- mem_ready is ignored in states that perform no memory access.
- ALUOp 00 = add, 01 = sub, 10 = funct-decoded; it is internal only.
- Latencies in cycles, with mem_ready tied high:
  - R/I-ALU: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - jal: 4
  - Each additional low mem_ready cycle adds 1.
- Reset mid-instruction aborts it with no partial write after rst falls.

Decomposition:
- Shared package holds:
  - State encoding: 4-bit localparams FETCH..TRAP.
  - Opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL.
  - ALUOp, ResultSrc, ALUSrcA/B and ImmSrc encodings.
- One sub-module: the existing ALU_Decoder, fed by the internal ALUOp.
- Next-state and output decode live in the top-level block.

Test Plan:
- add (Op = 0110011, f3 = 000, f7 = 0), mem_ready = 1 → states FETCH, DECODE, EXECR, ALUWB.
  - ALUControl = 000 in EXECR.
  - RegWrite = 1 in cycle 4 only; instr_retired pulses in cycle 4.
- lw with mem_ready low for 3 cycles in MEMREAD → stays in MEMREAD with AdrSrc = 1 for 3 extra cycles.
  - Then MEMWB: ResultSrc = 01, RegWrite = 1. Total 8 cycles.
- beq with Zero = 1, then beq with Zero = 0 → PCWrite = 1 and PCWrite = 0 respectively in the BEQ cycle; ALUControl = 001; both take 3 cycles.
- Op = 0000000 → DECODE → TRAP. trap = 1, all enables 0 for 20+ cycles.
  - Assert rst low → FETCH, trap = 0.
- sw with mem_ready held low and MEM_TIMEOUT = 15 → MemWrite held 16 cycles in MEMWRITE, then TRAP.
  - Repeat with MEM_TIMEOUT = 0 → no trap; completes on mem_ready.
- Assert rst low during MEMWB of lw → RegWrite falls immediately (asynchronous); state = FETCH after release.
